// File: rtl/cpu_pkg.sv
// Purpose: shared CPU definitions (condition codes, flag bit positions).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Predication condition codes carried by every instruction.
    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_EQ = 3'd1,
        COND_NE = 3'd2,
        COND_LT = 3'd3,
        COND_GE = 3'd4,
        COND_GT = 3'd5,
        COND_LE = 3'd6,
        COND_NV = 3'd7
    } cond_t;

    // Bit positions inside the 2-bit flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;

endpackage

// File: rtl/cond_check.sv
// Purpose: evaluate a condition code against an N/Z flag vector.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cond (3b code), flags (bit0 Z, bit1 N) -> pass (1 = condition holds).
module cond_check
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [1:0] flags,
    output logic       pass
);

    logic z;
    logic n;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_LT: pass = n;
            COND_GE: pass = ~n;
            COND_GT: pass = ~n & ~z;
            COND_LE: pass = n | z;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_commit.sv
// Purpose: execute-stage commit: N/Z flag register, predication, EX/MEM pipeline register.
// Latency: 1 cycle from execute inputs to *_m outputs; cond_ex/branch_taken combinational.
// Backpressure: stall holds EX/MEM and blocks flag writes; flush clears EX/MEM controls (flush beats stall).
// Ports: clk/rst (sync, active-high); execute inputs valid_in, alu_result, alu_flags, store_data,
//        rd, cond, flag_write, reg_write, mem_write, mem_to_reg, branch, stall, flush;
//        outputs flags_q, cond_ex, branch_taken and registered valid_m, reg_write_m,
//        mem_write_m, mem_to_reg_m, result_m, store_data_m, rd_m.
module execute_commit
    import cpu_pkg::*;
#(
    parameter int N  = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [N-1:0]  alu_result,
    input  logic [1:0]    alu_flags,
    input  logic [N-1:0]  store_data,
    input  logic [RW-1:0] rd,
    input  logic [2:0]    cond,
    input  logic          flag_write,
    input  logic          reg_write,
    input  logic          mem_write,
    input  logic          mem_to_reg,
    input  logic          branch,
    input  logic          stall,
    input  logic          flush,
    output logic [1:0]    flags_q,
    output logic          cond_ex,
    output logic          branch_taken,
    output logic          valid_m,
    output logic          reg_write_m,
    output logic          mem_write_m,
    output logic          mem_to_reg_m,
    output logic [N-1:0]  result_m,
    output logic [N-1:0]  store_data_m,
    output logic [RW-1:0] rd_m
);

    logic commit;
    logic flag_en;

    // Conditions read the registered flags only; a flag-setting instruction
    // therefore affects the next instruction, never itself.
    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags_q),
        .pass  (cond_ex)
    );

    assign commit       = valid_in & cond_ex;
    assign flag_en      = commit & flag_write & ~stall & ~flush;
    assign branch_taken = valid_in & branch & cond_ex & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 2'b00;
        end else if (flag_en) begin
            flags_q <= alu_flags;
        end
    end

    // EX/MEM register. A failed-condition instruction still moves down the
    // pipe as valid, but with every write control stripped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            result_m     <= '0;
            store_data_m <= '0;
            rd_m         <= '0;
        end else if (!stall) begin
            valid_m      <= valid_in;
            reg_write_m  <= reg_write & commit;
            mem_write_m  <= mem_write & commit;
            mem_to_reg_m <= mem_to_reg & commit;
            result_m     <= alu_result;
            store_data_m <= store_data;
            rd_m         <= rd;
        end
    end

endmodule

// File: tb/tb_execute_commit.sv
module tb_execute_commit;

    localparam int N  = 32;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [N-1:0]  alu_result;
    logic [1:0]    alu_flags;
    logic [N-1:0]  store_data;
    logic [RW-1:0] rd;
    logic [2:0]    cond;
    logic          flag_write, reg_write, mem_write, mem_to_reg, branch, stall, flush;
    logic [1:0]    flags_q;
    logic          cond_ex, branch_taken;
    logic          valid_m, reg_write_m, mem_write_m, mem_to_reg_m;
    logic [N-1:0]  result_m, store_data_m;
    logic [RW-1:0] rd_m;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    execute_commit #(.N(N), .RW(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .store_data   (store_data),
        .rd           (rd),
        .cond         (cond),
        .flag_write   (flag_write),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .branch       (branch),
        .stall        (stall),
        .flush        (flush),
        .flags_q      (flags_q),
        .cond_ex      (cond_ex),
        .branch_taken (branch_taken),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .mem_write_m  (mem_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .result_m     (result_m),
        .store_data_m (store_data_m),
        .rd_m         (rd_m)
    );

    always #5 clk = ~clk;

    // Truth table of the condition codes: nibble c holds pass for flags {N,Z} = 3..0.
    function automatic logic model_pass(input logic [2:0] c, input logic [1:0] f);
        logic [31:0] tbl;
        tbl = 32'h0E13_C5AF;
        return tbl[{c, f}];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]    m_flags;
    logic          m_valid, m_rw, m_mw, m_mtr;
    logic [N-1:0]  m_res, m_sd;
    logic [RW-1:0] m_rd;

    always @(posedge clk) begin
        logic ok;
        if (rst) begin
            m_flags = 2'b00; m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0;
            m_res = '0; m_sd = '0; m_rd = '0;
        end else begin
            ok = valid_in && model_pass(cond, m_flags);
            if (ok && flag_write && !stall && !flush) m_flags = alu_flags;
            if (flush) begin
                m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0;
                m_res = '0; m_sd = '0; m_rd = '0;
            end else if (!stall) begin
                m_valid = valid_in;
                m_rw    = reg_write && ok;
                m_mw    = mem_write && ok;
                m_mtr   = mem_to_reg && ok;
                m_res   = alu_result;
                m_sd    = store_data;
                m_rd    = rd;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.flags_q",      32'(flags_q),      32'(m_flags));
            chk("m.cond_ex",      32'(cond_ex),      32'(model_pass(cond, m_flags)));
            chk("m.branch_taken", 32'(branch_taken),
                32'(valid_in && branch && !stall && model_pass(cond, m_flags)));
            chk("m.valid_m",      32'(valid_m),      32'(m_valid));
            chk("m.reg_write_m",  32'(reg_write_m),  32'(m_rw));
            chk("m.mem_write_m",  32'(mem_write_m),  32'(m_mw));
            chk("m.mem_to_reg_m", 32'(mem_to_reg_m), 32'(m_mtr));
            chk("m.rd_m",         32'(rd_m),         32'(m_rd));
            if (m_valid) begin
                chk("m.result_m",     result_m,     m_res);
                chk("m.store_data_m", store_data_m, m_sd);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 0; alu_result = '0; alu_flags = 2'b00; store_data = '0; rd = '0;
        cond = 3'd0; flag_write = 0; reg_write = 0; mem_write = 0; mem_to_reg = 0;
        branch = 0; stall = 0; flush = 0;
    endtask

    initial begin
        // Reset with every input driven high.
        rst = 1; valid_in = 1; alu_result = '1; alu_flags = 2'b11; store_data = '1; rd = '1;
        cond = 3'd7; flag_write = 1; reg_write = 1; mem_write = 1; mem_to_reg = 1;
        branch = 1; stall = 1; flush = 1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst.flags_q",  32'(flags_q), 32'h0);
        chk("rst.valid_m",  32'(valid_m), 32'h0);
        chk("rst.ctrl_m",   32'({reg_write_m, mem_write_m, mem_to_reg_m}), 32'h0);
        chk("rst.result_m", result_m, 32'h0);
        chk("rst.rd_m",     32'(rd_m), 32'h0);
        rst = 0;
        idle();
        tick();

        // Compare then EQ.
        valid_in = 1; cond = 3'd0; flag_write = 1; alu_flags = 2'b01;
        tick();
        chk("cmp.flags_q", 32'(flags_q), 32'h1);
        idle();
        valid_in = 1; cond = 3'd1; reg_write = 1; alu_result = 32'd5; rd = 4'd3;
        #1;
        chk("eq.cond_ex", 32'(cond_ex), 32'h1);
        tick();
        chk("eq.valid_m",     32'(valid_m), 32'h1);
        chk("eq.reg_write_m", 32'(reg_write_m), 32'h1);
        chk("eq.result_m",    result_m, 32'd5);
        chk("eq.rd_m",        32'(rd_m), 32'd3);

        // Failed condition: NE with Z set.
        idle();
        valid_in = 1; cond = 3'd2; mem_write = 1; flag_write = 1; alu_flags = 2'b10;
        #1;
        chk("ne.cond_ex", 32'(cond_ex), 32'h0);
        tick();
        chk("ne.valid_m",     32'(valid_m), 32'h1);
        chk("ne.mem_write_m", 32'(mem_write_m), 32'h0);
        chk("ne.flags_q",     32'(flags_q), 32'h1);

        // Branch: clear flags, then GT taken (and it also sets N=1).
        idle();
        valid_in = 1; cond = 3'd0; flag_write = 1; alu_flags = 2'b00;
        tick();
        idle();
        valid_in = 1; cond = 3'd5; branch = 1; flag_write = 1; alu_flags = 2'b10;
        #1;
        chk("gt00.branch_taken", 32'(branch_taken), 32'h1);
        tick();
        chk("gt.flags_q", 32'(flags_q), 32'h2);
        flag_write = 0;
        #1;
        chk("gt10.branch_taken", 32'(branch_taken), 32'h0);
        idle();
        valid_in = 1; cond = 3'd0; flag_write = 1; alu_flags = 2'b00;
        tick();
        idle();
        valid_in = 1; cond = 3'd5; branch = 1; stall = 1;
        #1;
        chk("gtstall.branch_taken", 32'(branch_taken), 32'h0);
        tick();

        // Stall holds EX/MEM and flags; stall+flush clears.
        idle();
        valid_in = 1; cond = 3'd0; alu_result = 32'd7;
        tick();
        chk("ld.result_m", result_m, 32'd7);
        stall = 1; alu_result = 32'd9; flag_write = 1; alu_flags = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.result_m", result_m, 32'd7);
            chk("stall.flags_q",  32'(flags_q), 32'h0);
        end
        flush = 1;
        tick();
        chk("flush.valid_m", 32'(valid_m), 32'h0);
        chk("flush.flags_q", 32'(flags_q), 32'h0);

        // Mid-stream reset beats a flag write.
        idle();
        valid_in = 1; cond = 3'd0; flag_write = 1; alu_flags = 2'b11; reg_write = 1; rst = 1;
        tick();
        chk("mrst.flags_q",     32'(flags_q), 32'h0);
        chk("mrst.reg_write_m", 32'(reg_write_m), 32'h0);
        rst = 0;
        idle();
        tick();

        // Sweep every condition against every flag value, checked by the model.
        for (int i = 0; i < 32; i++) begin
            idle();
            valid_in = 1; cond = 3'd0; flag_write = 1; alu_flags = 2'(i);
            tick();
            idle();
            valid_in = 1; cond = 3'(i >> 2); reg_write = 1; mem_write = 1; mem_to_reg = 1;
            branch = 1; alu_result = 32'(i * 3 + 1); store_data = 32'(i ^ 32'h55); rd = 4'(i);
            stall = (i % 5 == 3); flush = (i % 7 == 6);
            flag_write = 1; alu_flags = 2'(~i);
            tick();
        end
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
